// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared types and constants for the multi-digit 7-segment display bank.
//   seg7_t      : 7-bit segment vector ordered {g,f,e,d,c,b,a}
//   nibble_t    : 4-bit hex digit
//   SEG_TABLE   : active-high segment patterns for hex digits 0..F
//   SEG_BLANK_N : active-low pattern with every segment off
// -----------------------------------------------------------------------------
package seven_seg_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [3:0] nibble_t;

  localparam seg7_t SEG_BLANK_N = 7'h7F;

  // Active-high {g,f,e,d,c,b,a}; index is the hex digit value.
  localparam seg7_t SEG_TABLE [16] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111,  // 9
    7'b1110111,  // A
    7'b1111100,  // b
    7'b0111001,  // C
    7'b1011110,  // d
    7'b1111001,  // E
    7'b1110001   // F
  };

endpackage

// File: rtl/seg7_hex_lut.sv
// -----------------------------------------------------------------------------
// seg7_hex_lut
// Purely combinational hex-nibble to active-high 7-segment lookup.
// Ports:
//   nibble : input  4-bit hex digit
//   seg    : output active-high segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_hex_lut
  import seven_seg_pkg::*;
(
  input  nibble_t nibble,
  output seg7_t   seg
);

  // All 16 codes are covered, so the output is never X for a known input.
  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_display_bank.sv
// -----------------------------------------------------------------------------
// seven_seg_display_bank
// Multi-digit hex display driver. A load strobe captures a packed hex word,
// per-digit enables and a blink mask; every clock the captured digits are
// decoded to active-low segments and registered onto ssOut. A free-running
// prescaler toggles blink_phase every BLINK_DIV cycles; blinking digits are
// blanked while blink_phase is 0.
//
// Optional build macro SEVEN_SEG_LZB_EN: blank leading zero digits (digit 0
// is always shown). Without it, zeros display as "0".
//
// Parameters:
//   NUM_DIGITS : number of digits driven (1..8)
//   BLINK_DIV  : clk cycles per blink half-period (>=1)
// Ports:
//   clk         : input  system clock
//   rst_n       : input  asynchronous active-low reset
//   load        : input  capture strobe for value/digit_en/blink_mask
//   value       : input  packed hex digits, nibble i feeds digit i
//   digit_en    : input  per-digit enable (0 = forced blank)
//   blink_mask  : input  per-digit blink select
//   ssOut       : output active-low segments, ssOut[7i+6:7i] = digit i {g..a}
//   blink_phase : output current blink phase, 1 = visible
// -----------------------------------------------------------------------------
module seven_seg_display_bank
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] ssOut,
  output logic                    blink_phase
);

  localparam int            PRE_W    = $clog2(BLINK_DIV + 1);
  localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(BLINK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0]        prescale;

  logic [4*NUM_DIGITS-1:0] valueReg_p1;
  logic [NUM_DIGITS-1:0]   digitEnReg_p1;
  logic [NUM_DIGITS-1:0]   blinkMaskReg_p1;

  seg7_t                   segHi [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lzBlank;
  logic [7*NUM_DIGITS-1:0] ssNext;

  // Blink prescaler: runs regardless of load so reloads never shift the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale    <= '0;
      blink_phase <= 1'b1;
    end else if (prescale == PRE_TERM) begin
      prescale    <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      prescale    <= prescale + PRE_ONE;
    end
  end

  // ---- Stage 1: capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valueReg_p1     <= '0;
      digitEnReg_p1   <= '0;
      blinkMaskReg_p1 <= '0;
    end else if (load) begin
      valueReg_p1     <= value;
      digitEnReg_p1   <= digit_en;
      blinkMaskReg_p1 <= blink_mask;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gDigit
    seg7_hex_lut uLut (
      .nibble (valueReg_p1[4*g +: 4]),
      .seg    (segHi[g])
    );
  end

`ifdef SEVEN_SEG_LZB_EN
  // Walk down from the top digit; blank zeros until the first nonzero nibble.
  // Digit 0 is excluded so an all-zero word still shows a single "0".
  always_comb begin
    logic leading;
    lzBlank = '0;
    leading = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (leading && (valueReg_p1[4*i +: 4] == 4'h0)) begin
        lzBlank[i] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  assign lzBlank = '0;
`endif

  always_comb begin
    ssNext = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!digitEnReg_p1[i] || (blinkMaskReg_p1[i] && !blink_phase) || lzBlank[i]) begin
        ssNext[7*i +: 7] = SEG_BLANK_N;
      end else begin
        ssNext[7*i +: 7] = ~segHi[i];
      end
    end
  end

  // ---- Stage 2: decoded, blanked, active-low output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssOut <= '1;
    end else begin
      ssOut <= ssNext;
    end
  end

endmodule

// File: tb/tb_seven_seg_display_bank.sv
module tb_seven_seg_display_bank;

  localparam int ND = 4;
  localparam int BD = 4;

  // Active-low patterns for hex digits 0..F.
  localparam logic [6:0] LOW_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load = 1'b0;
  logic [4*ND-1:0] value = '0;
  logic [ND-1:0]   digit_en = '0;
  logic [ND-1:0]   blink_mask = '0;
  logic [7*ND-1:0] ssOut;
  logic            blink_phase;

  int checkCount = 0;
  int errCount   = 0;
  int edgeN      = 0;

  seven_seg_display_bank #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .value       (value),
    .digit_en    (digit_en),
    .blink_mask  (blink_mask),
    .ssOut       (ssOut),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edgeN <= 0;
    else        edgeN <= edgeN + 1;
  end

  task automatic checkVal(input string tag, input logic [27:0] got, input logic [27:0] want);
    checkCount++;
    if (got !== want) begin
      errCount++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Phase after edge n since reset: toggles at edges 4, 8, 12, ...
  function automatic logic expPhase(input int n);
    return ((n / BD) % 2) == 0;
  endfunction

  function automatic logic [27:0] expSeg(input logic [15:0] v, input logic [3:0] en,
                                         input logic [3:0] mask, input logic ph);
    logic [27:0] r;
    logic [3:0]  nib;
    r = '1;
    for (int i = 0; i < 4; i++) begin
      nib = v[4*i +: 4];
      r[7*i +: 7] = (!en[i] || (mask[i] && !ph)) ? 7'h7F : LOW_TAB[nib];
    end
    return r;
  endfunction

  logic [15:0] dispVal;

  initial begin
    // 1. Reset with clock running, then asynchronous reset mid-cycle.
    repeat (3) @(negedge clk);
    checkVal("rst_ss", ssOut, 28'hFFFFFFF);
    checkVal("rst_phase", {27'b0, blink_phase}, 28'h1);
    rst_n = 1'b1;
    load = 1'b1; value = 16'h1234; digit_en = 4'hF; blink_mask = 4'h0;
    tick();
    load = 1'b0;
    tick();
    tick();
    checkVal("pre_async_ss", ssOut, {7'h79, 7'h24, 7'h30, 7'h19});
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkVal("async_ss", ssOut, 28'hFFFFFFF);
    checkVal("async_phase", {27'b0, blink_phase}, 28'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. Basic decode and latency.
    load = 1'b1; value = 16'h1234; digit_en = 4'hF; blink_mask = 4'h0;
    tick();
    load = 1'b0;
    checkVal("lat_blank", ssOut, 28'hFFFFFFF);
    tick();
    checkVal("dec_1234", ssOut, {7'h79, 7'h24, 7'h30, 7'h19});
    tick(); tick();
    checkVal("dec_hold", ssOut, {7'h79, 7'h24, 7'h30, 7'h19});

    // 3. Blink on digit 0, with a reload mid-period.
    load = 1'b1; value = 16'h1234; digit_en = 4'hF; blink_mask = 4'b0001;
    tick();
    load = 1'b0;
    tick();
    dispVal = 16'h1234;
    for (int i = 0; i < 14; i++) begin
      checkVal($sformatf("blink_ss%0d", i), ssOut,
               expSeg(dispVal, 4'hF, 4'b0001, expPhase(edgeN - 1)));
      checkVal($sformatf("blink_ph%0d", i), {27'b0, blink_phase}, {27'b0, expPhase(edgeN)});
      if (i == 5) begin
        load = 1'b1; value = 16'h5234;
      end
      if (i == 6) load = 1'b0;
      tick();
      if (i == 6) dispVal = 16'h5234;
    end

    // 4. Per-digit enable.
    load = 1'b1; value = 16'hABCD; digit_en = 4'b0101; blink_mask = 4'h0;
    tick();
    load = 1'b0;
    tick();
    checkVal("en_0101", ssOut, {7'h7F, 7'h03, 7'h7F, 7'h21});

    // 5. Leading-zero blanking.
    load = 1'b1; value = 16'h0050; digit_en = 4'hF;
    tick();
    load = 1'b0;
    tick();
`ifdef SEVEN_SEG_LZB_EN
    checkVal("lzb_0050", ssOut, {7'h7F, 7'h7F, 7'h12, 7'h40});
`else
    checkVal("lzb_0050", ssOut, {7'h40, 7'h40, 7'h12, 7'h40});
`endif
    load = 1'b1; value = 16'h0000;
    tick();
    load = 1'b0;
    tick();
`ifdef SEVEN_SEG_LZB_EN
    checkVal("lzb_0000", ssOut, {7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
    checkVal("lzb_0000", ssOut, {7'h40, 7'h40, 7'h40, 7'h40});
`endif

    // 6. Back-to-back loads.
    load = 1'b1; value = 16'h1111;
    tick();
    value = 16'h2222;
    tick();
    load = 1'b0;
    checkVal("b2b_first", ssOut, {4{7'h79}});
    tick();
    checkVal("b2b_second", ssOut, {4{7'h24}});
    tick();
    checkVal("b2b_hold", ssOut, {4{7'h24}});

    $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
    $finish;
  end

endmodule
